// File: rtl/vfm_core_msg_arbiter.sv
// Four-core round-robin message arbiter: one message in flight, held on the destination slice until acked.
// Optional delivery timeout enabled by defining MSG_ARB_TIMEOUT_EN.
module vfm_core_msg_arbiter #(
  parameter int DATA_W  = 14,
  parameter int TIMEOUT = 1023
) (
  input  logic                Clock_pin,
  input  logic                Resetn_pin,
  input  logic [3:0]          req_valid,
  input  logic [7:0]          req_dest,
  input  logic [4*DATA_W-1:0] req_data,
  output logic [3:0]          req_ready,
  output logic [3:0]          dlv_valid,
  output logic [4*DATA_W-1:0] dlv_data,
  output logic [7:0]          dlv_src,
  input  logic [3:0]          dlv_ack,
  output logic                busy,
  output logic [15:0]         msg_count,
  output logic                err_timeout
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] DELIVER = 1'b1;

  logic [0:0]        state;
  logic [1:0]        rr_ptr;
  logic [1:0]        winner;
  logic [1:0]        src;
  logic [1:0]        dest;
  logic [DATA_W-1:0] data;
  logic              accept;
  logic              ack_hit;
  logic              tmo_hit;

  // Descending scan so the requester closest above rr_ptr wins.
  always_comb begin
    winner = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[rr_ptr + 2'(k)]) winner = rr_ptr + 2'(k);
    end
  end

  assign accept    = (state == IDLE) && (|req_valid) && Resetn_pin;
  assign req_ready = accept ? (4'b0001 << winner) : 4'b0000;
  assign ack_hit   = (state == DELIVER) && dlv_ack[dest];
  assign busy      = (state == DELIVER);

`ifdef MSG_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  assign tmo_hit     = (state == DELIVER) && !ack_hit && (tmo_cnt == TW'(TIMEOUT - 1));
  assign err_timeout = err_q;

  always_ff @(posedge Clock_pin) begin
    if (!Resetn_pin) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= tmo_hit;
      if (accept) begin
        tmo_cnt <= '0;
      end else if (state == DELIVER) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign tmo_hit        = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  always_ff @(posedge Clock_pin) begin
    if (!Resetn_pin) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      src       <= 2'd0;
      dest      <= 2'd0;
      data      <= '0;
      msg_count <= 16'd0;
    end else if (state == IDLE) begin
      if (accept) begin
        state  <= DELIVER;
        src    <= winner;
        dest   <= req_dest[{winner, 1'b0} +: 2];
        data   <= req_data[winner * DATA_W +: DATA_W];
        rr_ptr <= winner + 2'd1;
      end
    end else begin
      if (ack_hit) begin
        state     <= IDLE;
        msg_count <= msg_count + 16'd1;
      end else if (tmo_hit) begin
        state <= IDLE;
      end
    end
  end

  always_comb begin
    dlv_valid = '0;
    dlv_data  = '0;
    dlv_src   = '0;
    if (state == DELIVER) begin
      dlv_valid[dest]                  = 1'b1;
      dlv_data[dest * DATA_W +: DATA_W] = data;
      dlv_src[{dest, 1'b0} +: 2]       = src;
    end
  end

endmodule

// File: tb/tb_vfm_core_msg_arbiter.sv
// Directed bench for vfm_core_msg_arbiter: inputs driven 1 time unit after the rising edge, outputs checked before the next edge.
module tb_vfm_core_msg_arbiter;
  localparam int DATA_W = 14;

  logic                Clock_pin = 1'b0;
  logic                Resetn_pin;
  logic [3:0]          req_valid;
  logic [7:0]          req_dest;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_ready;
  logic [3:0]          dlv_valid;
  logic [4*DATA_W-1:0] dlv_data;
  logic [7:0]          dlv_src;
  logic [3:0]          dlv_ack;
  logic                busy;
  logic [15:0]         msg_count;
  logic                err_timeout;

  int tests_run    = 0;
  int tests_failed = 0;

  vfm_core_msg_arbiter #(.DATA_W(DATA_W), .TIMEOUT(8)) dut (
    .Clock_pin(Clock_pin), .Resetn_pin(Resetn_pin),
    .req_valid(req_valid), .req_dest(req_dest), .req_data(req_data), .req_ready(req_ready),
    .dlv_valid(dlv_valid), .dlv_data(dlv_data), .dlv_src(dlv_src), .dlv_ack(dlv_ack),
    .busy(busy), .msg_count(msg_count), .err_timeout(err_timeout)
  );

  always #5 Clock_pin = ~Clock_pin;

  task automatic tick();
    @(posedge Clock_pin);
    #1;
  endtask

  task automatic do_reset();
    Resetn_pin = 1'b0;
    tick();
    Resetn_pin = 1'b1;
  endtask

  task automatic test_reset();
    Resetn_pin = 1'b0; req_valid = 4'hF; req_dest = '0; req_data = '0; dlv_ack = '0;
    tick(); tick();
    tests_run++;
    if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    tests_run++;
    if (dlv_valid !== 4'b0000 || busy !== 1'b0 || msg_count !== 16'd0 || err_timeout !== 1'b0) begin
      tests_failed++; $display("FAIL reset_state got vld=%b busy=%b cnt=%0d err=%b exp 0000/0/0/0", dlv_valid, busy, msg_count, err_timeout);
    end
    tests_run++;
    if (dlv_data !== '0 || dlv_src !== 8'h00) begin tests_failed++; $display("FAIL reset_slices got data=%h src=%h exp 0/0", dlv_data, dlv_src); end
    req_valid = 4'h0;
    Resetn_pin = 1'b1;
  endtask

  task automatic test_single();
    req_valid = 4'b0010; req_dest = 8'h00; req_data = '0; req_data[DATA_W +: DATA_W] = 14'h1ABC; dlv_ack = 4'b0001;
    #1;
    tests_run++;
    if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL single_ready got %b exp 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    tests_run++;
    if (dlv_valid !== 4'b0001 || busy !== 1'b1) begin tests_failed++; $display("FAIL single_deliver got vld=%b busy=%b exp 0001/1", dlv_valid, busy); end
    tests_run++;
    if (dlv_data[0 +: DATA_W] !== 14'h1ABC || dlv_src[1:0] !== 2'd1) begin
      tests_failed++; $display("FAIL single_payload got data=%h src=%0d exp 1abc/1", dlv_data[0 +: DATA_W], dlv_src[1:0]);
    end
    tick();
    tests_run++;
    if (dlv_valid !== 4'b0000 || busy !== 1'b0 || msg_count !== 16'd1) begin
      tests_failed++; $display("FAIL single_done got vld=%b busy=%b cnt=%0d exp 0000/0/1", dlv_valid, busy, msg_count);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_w;
    do_reset();
    req_valid = 4'hF; req_dest = 8'h00; dlv_ack = 4'b0001;
    for (int i = 0; i < 4; i++) req_data[i*DATA_W +: DATA_W] = 14'(16'h0100 + i);
    for (int m = 0; m < 5; m++) begin
      exp_w = 2'(m % 4);
      #1;
      tests_run++;
      if (req_ready !== (4'b0001 << exp_w)) begin tests_failed++; $display("FAIL rr_grant%0d got %b exp %b", m, req_ready, 4'b0001 << exp_w); end
      tick();
      tests_run++;
      if (dlv_valid !== 4'b0001 || dlv_src[1:0] !== exp_w || dlv_data[0 +: DATA_W] !== 14'(16'h0100 + exp_w) || req_ready !== 4'b0000) begin
        tests_failed++; $display("FAIL rr_deliver%0d got vld=%b src=%0d data=%h rdy=%b exp 0001/%0d/%h/0000", m, dlv_valid, dlv_src[1:0], dlv_data[0 +: DATA_W], req_ready, exp_w, 14'(16'h0100 + exp_w));
      end
      tick();
    end
    req_valid = 4'h0;
    #1;
    tests_run++;
    if (msg_count !== 16'd5) begin tests_failed++; $display("FAIL rr_count got %0d exp 5", msg_count); end
  endtask

  task automatic test_hold();
    req_valid = 4'b0100; req_dest = 8'h30; req_data = '0; req_data[2*DATA_W +: DATA_W] = 14'h2345; dlv_ack = 4'b0000;
    #1;
    tests_run++;
    if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL hold_ready got %b exp 0100", req_ready); end
    tick();
    req_valid = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      dlv_ack = (i % 2 == 1) ? 4'b0111 : 4'b0000;
      #1;
      tests_run++;
      if (dlv_valid !== 4'b1000 || dlv_data[3*DATA_W +: DATA_W] !== 14'h2345 || dlv_src[7:6] !== 2'd2 ||
          msg_count !== 16'd5 || req_ready !== 4'b0000 || err_timeout !== 1'b0) begin
        tests_failed++; $display("FAIL hold_cycle%0d got vld=%b data=%h src=%0d cnt=%0d rdy=%b err=%b exp 1000/2345/2/5/0000/0", i, dlv_valid, dlv_data[3*DATA_W +: DATA_W], dlv_src[7:6], msg_count, req_ready, err_timeout);
      end
      tick();
    end
    dlv_ack = 4'b1000;
    tick();
    tests_run++;
    if (dlv_valid !== 4'b0000 || msg_count !== 16'd6) begin tests_failed++; $display("FAIL hold_ack got vld=%b cnt=%0d exp 0000/6", dlv_valid, msg_count); end
    tests_run++;
    if (req_ready !== 4'b1000) begin tests_failed++; $display("FAIL hold_next_grant got %b exp 1000", req_ready); end
    req_valid = 4'b0000; dlv_ack = 4'b0000;
    tick();
    tests_run++;
    if (busy !== 1'b0 || msg_count !== 16'd6) begin tests_failed++; $display("FAIL drop_request got busy=%b cnt=%0d exp 0/6", busy, msg_count); end
  endtask

  task automatic test_reset_deliver();
    do_reset();
    req_valid = 4'b0010; req_dest = 8'h08; dlv_ack = 4'b0000;
    tick();
    tests_run++;
    if (busy !== 1'b1 || dlv_valid !== 4'b0100) begin tests_failed++; $display("FAIL rstdlv_busy got busy=%b vld=%b exp 1/0100", busy, dlv_valid); end
    Resetn_pin = 1'b0; req_valid = 4'b1001;
    #1;
    tests_run++;
    if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL rstdlv_ready_in_reset got %b exp 0000", req_ready); end
    tick();
    tests_run++;
    if (dlv_valid !== 4'b0000 || busy !== 1'b0 || msg_count !== 16'd0 || err_timeout !== 1'b0) begin
      tests_failed++; $display("FAIL rstdlv_cleared got vld=%b busy=%b cnt=%0d err=%b exp 0000/0/0/0", dlv_valid, busy, msg_count, err_timeout);
    end
    Resetn_pin = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL rstdlv_ptr got %b exp 0001", req_ready); end
    req_valid = 4'b1000; req_dest = 8'h40; req_data = '0; req_data[3*DATA_W +: DATA_W] = 14'h0777; dlv_ack = 4'b0010;
    #1;
    tests_run++;
    if (req_ready !== 4'b1000) begin tests_failed++; $display("FAIL rstdlv_core3_ready got %b exp 1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    tests_run++;
    if (dlv_valid !== 4'b0010 || dlv_src[3:2] !== 2'd3 || dlv_data[DATA_W +: DATA_W] !== 14'h0777) begin
      tests_failed++; $display("FAIL rstdlv_core3_deliver got vld=%b src=%0d data=%h exp 0010/3/0777", dlv_valid, dlv_src[3:2], dlv_data[DATA_W +: DATA_W]);
    end
    tick();
    tests_run++;
    if (msg_count !== 16'd1 || busy !== 1'b0) begin tests_failed++; $display("FAIL rstdlv_core3_done got cnt=%0d busy=%b exp 1/0", msg_count, busy); end
  endtask

  task automatic test_self_send();
    req_valid = 4'b0001; req_dest = 8'h00; req_data = '0; req_data[0 +: DATA_W] = 14'h0005; dlv_ack = 4'b0001;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL self_ready got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    tests_run++;
    if (dlv_valid !== 4'b0001 || dlv_data[0 +: DATA_W] !== 14'h0005 || dlv_src[1:0] !== 2'd0) begin
      tests_failed++; $display("FAIL self_deliver got vld=%b data=%h src=%0d exp 0001/0005/0", dlv_valid, dlv_data[0 +: DATA_W], dlv_src[1:0]);
    end
    tick();
    tests_run++;
    if (msg_count !== 16'd2) begin tests_failed++; $display("FAIL self_count got %0d exp 2", msg_count); end
    dlv_ack = 4'hF;
    tick();
    tests_run++;
    if (msg_count !== 16'd2 || busy !== 1'b0) begin tests_failed++; $display("FAIL idle_ack got cnt=%0d busy=%b exp 2/0", msg_count, busy); end
    dlv_ack = 4'h0;
  endtask

`ifdef MSG_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_valid = 4'b0001; req_dest = 8'h02; dlv_ack = 4'b0000;
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (busy !== 1'b1 || err_timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_wait%0d got busy=%b err=%b exp 1/0", i, busy, err_timeout); end
      tick();
    end
    tests_run++;
    if (busy !== 1'b0 || err_timeout !== 1'b1 || msg_count !== 16'd0) begin
      tests_failed++; $display("FAIL tmo_drop got busy=%b err=%b cnt=%0d exp 0/1/0", busy, err_timeout, msg_count);
    end
    tick();
    tests_run++;
    if (err_timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_pulse got %b exp 0", err_timeout); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_reset_deliver();
    test_self_send();
`ifdef MSG_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
